// File: rtl/bin2bcd_if.sv
// Start/done handshake and result bus between the calculator sequencer and bin2bcd_seq.
interface bin2bcd_if #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
);
  logic                  start;
  logic [WIDTH-1:0]      bin_in;
  logic [4*DIGITS-1:0]   bcd_out;
  logic                  overflow;
  logic [DIGITS-1:0]     blank;
  logic                  busy;
  logic                  done;

  modport master (
    output start, bin_in,
    input  bcd_out, overflow, blank, busy, done
  );

  modport slave (
    input  start, bin_in,
    output bcd_out, overflow, blank, busy, done
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one bit per ADJ/SHIFT pair.
// Optional leading-zero blank mask enabled by defining LEADING_ZERO_BLANK_EN.
module bin2bcd_seq #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic       clk,
  input  logic       rst,
  bin2bcd_if.slave   bus,
  output logic [1:0] state_dbg
);

  localparam int BW = 4 * DIGITS;
  localparam int SW = WIDTH + BW;
  localparam int CW = $clog2(WIDTH + 1);

  // Handshake: start is a level request sampled only in IDLE; the sequencer holds it
  // until done rises. done stays high while start is high and falls the edge after
  // start is seen low, returning to IDLE. A new request needs start low for a cycle.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ADJ   = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [SW-1:0] sr;
  logic [SW-1:0] adj_val;
  logic [CW-1:0] cnt;
  logic          ovf_acc;
  logic [BW-1:0] bcd_q;
  logic          ovf_q;
  logic          busy_q;
  logic          done_q;

  logic load, do_adj, do_shift, capture, drop;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.start) state_nxt = S_ADJ;
      S_ADJ:   state_nxt = S_SHIFT;
      S_SHIFT: state_nxt = (cnt == CW'(1)) ? S_DONE : S_ADJ;
      S_DONE:  if (done_q && !bus.start) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output/control decode; results are captured on the first cycle spent in DONE
  always_comb begin
    load     = 1'b0;
    do_adj   = 1'b0;
    do_shift = 1'b0;
    capture  = 1'b0;
    drop     = 1'b0;
    case (state)
      S_IDLE:  load     = bus.start;
      S_ADJ:   do_adj   = 1'b1;
      S_SHIFT: do_shift = 1'b1;
      S_DONE: begin
        capture = !done_q;
        drop    = done_q && !bus.start;
      end
      default: ;
    endcase
  end

  // Every digit is judged on its pre-adjust value, so all digits adjust in parallel
  always_comb begin
    adj_val = sr;
    for (int i = 0; i < DIGITS; i++) begin
      if (sr[WIDTH+4*i +: 4] >= 4'd5)
        adj_val[WIDTH+4*i +: 4] = sr[WIDTH+4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr      <= '0;
      cnt     <= '0;
      ovf_acc <= 1'b0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      if (load) begin
        sr      <= {{BW{1'b0}}, bus.bin_in};
        cnt     <= CW'(WIDTH);
        ovf_acc <= 1'b0;
        busy_q  <= 1'b1;
      end
      if (do_adj) sr <= adj_val;
      if (do_shift) begin
        sr      <= sr << 1;
        ovf_acc <= ovf_acc | sr[SW-1];
        cnt     <= cnt - 1'b1;
      end
      if (capture) begin
        bcd_q  <= sr[SW-1 -: BW];
        ovf_q  <= ovf_acc;
        busy_q <= 1'b0;
        done_q <= 1'b1;
      end
      if (drop) done_q <= 1'b0;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] blank_nxt;
  logic [DIGITS-1:0] blank_q;
  logic              seen_nz;

  // Blank every digit above the most significant nonzero one; digit 0 always shows
  always_comb begin
    blank_nxt = '0;
    seen_nz   = 1'b0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (sr[WIDTH+4*i +: 4] != 4'd0) seen_nz = 1'b1;
      blank_nxt[i] = !seen_nz;
    end
    if (ovf_acc) blank_nxt = '0;
  end

  always_ff @(posedge clk) begin
    if (rst)          blank_q <= '0;
    else if (capture) blank_q <= blank_nxt;
  end

  assign bus.blank = blank_q;
`else
  assign bus.blank = '0;
`endif

  assign bus.bcd_out  = bcd_q;
  assign bus.overflow = ovf_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign state_dbg    = state;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: two instances (5 and 3 digits) share stimulus; a monitor
// pops expected results from per-instance queues filled by an arithmetic reference.
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] bin_in;
  logic [1:0]  state_a, state_b;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;

  bin2bcd_if #(.WIDTH(16), .DIGITS(5)) bus_a ();
  bin2bcd_if #(.WIDTH(16), .DIGITS(3)) bus_b ();

  assign bus_a.start  = start;
  assign bus_a.bin_in = bin_in;
  assign bus_b.start  = start;
  assign bus_b.bin_in = bin_in;

  bin2bcd_seq #(.WIDTH(16), .DIGITS(5)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a), .state_dbg(state_a)
  );
  bin2bcd_seq #(.WIDTH(16), .DIGITS(3)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b), .state_dbg(state_b)
  );

  // Clock
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard queues: {blank, overflow, bcd}
  logic [25:0] exp_a_q[$];
  logic [15:0] exp_b_q[$];
  int          load_q[$];
  logic [20:0] last_a = '0;
  logic [12:0] last_b = '0;
  logic        prev_a = 1'b0;
  logic        prev_b = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: plain decimal arithmetic
  function automatic int unsigned pow10(input int n);
    int unsigned p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  function automatic logic [31:0] ref_bcd(input int unsigned v, input int d);
    logic [31:0] r = '0;
    for (int i = 0; i < d; i++) r[4*i +: 4] = 4'((v / pow10(i)) % 10);
    return r;
  endfunction

  function automatic logic [7:0] ref_blank(input int unsigned v, input int d);
    logic [7:0] r = '0;
    if (v < pow10(d))
      for (int i = 1; i < d; i++) r[i] = (v < pow10(i));
`ifndef LEADING_ZERO_BLANK_EN
    r = '0;
`endif
    return r;
  endfunction

  function automatic logic [25:0] pack_a(input int unsigned v);
    logic [31:0] b = ref_bcd(v, 5);
    logic [7:0]  k = ref_blank(v, 5);
    return {k[4:0], (v >= pow10(5)), b[19:0]};
  endfunction

  function automatic logic [15:0] pack_b(input int unsigned v);
    logic [31:0] b = ref_bcd(v, 3);
    logic [7:0]  k = ref_blank(v, 3);
    return {k[2:0], (v >= pow10(3)), b[11:0]};
  endfunction

  // Monitor: compares on each rising done, and checks results hold while busy
  always @(negedge clk) begin
    logic [25:0] ea;
    logic [15:0] eb;
    int          ld;
    if (!rst) begin
      if (bus_a.done && !prev_a) begin
        if (exp_a_q.size() == 0) begin
          total++; bad++;
          $display("FAIL a_unexpected_done: got done with empty queue (cycle %0d)", cyc);
        end else begin
          ea = exp_a_q.pop_front();
          ld = load_q.pop_front();
          chk("a_bcd",      64'(bus_a.bcd_out),  64'(ea[19:0]));
          chk("a_overflow", 64'(bus_a.overflow), 64'(ea[20]));
          chk("a_blank",    64'(bus_a.blank),    64'(ea[25:21]));
          chk("a_busy_low", 64'(bus_a.busy),     64'd0);
          chk("a_latency",  64'(cyc - ld),       64'd33);
          last_a = ea[20:0];
        end
      end
      if (bus_b.done && !prev_b) begin
        if (exp_b_q.size() == 0) begin
          total++; bad++;
          $display("FAIL b_unexpected_done: got done with empty queue (cycle %0d)", cyc);
        end else begin
          eb = exp_b_q.pop_front();
          chk("b_bcd",      64'(bus_b.bcd_out),  64'(eb[11:0]));
          chk("b_overflow", 64'(bus_b.overflow), 64'(eb[12]));
          chk("b_blank",    64'(bus_b.blank),    64'(eb[15:13]));
          last_b = eb[12:0];
        end
      end
      if (bus_a.busy) chk("a_hold_prev", 64'({bus_a.overflow, bus_a.bcd_out}), 64'(last_a));
      if (bus_b.busy) chk("b_hold_prev", 64'({bus_b.overflow, bus_b.bcd_out}), 64'(last_b));
    end
    prev_a = bus_a.done;
    prev_b = bus_b.done;
  end

  task automatic issue(input int unsigned v);
    @(negedge clk);
    start  = 1'b1;
    bin_in = 16'(v);
    exp_a_q.push_back(pack_a(v));
    exp_b_q.push_back(pack_b(v));
    load_q.push_back(cyc + 1);
  endtask

  task automatic convert(input int unsigned v, input int hold);
    logic [25:0] ea = pack_a(v);
    int n = 0;
    issue(v);
    @(negedge clk);
    bin_in = 16'($urandom);
    while (!bus_a.done && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus_a.done) begin
      total++; bad++;
      $display("FAIL done_timeout: got no done after %0d cycles for value %0d", n, v);
    end
    repeat (hold) begin
      @(negedge clk);
      chk("hold_done", 64'(bus_a.done),    64'd1);
      chk("hold_bcd",  64'(bus_a.bcd_out), 64'(ea[19:0]));
    end
    start = 1'b0;
    @(negedge clk);
    chk("drop_done", 64'(bus_a.done), 64'd0);
    chk("drop_idle", 64'(state_a),    64'd0);
  endtask

  task automatic reset_mid(input int unsigned v);
    int ld;
    issue(v);
    ld = cyc + 1;
    while (cyc < ld + 9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_a_outs",  64'({bus_a.bcd_out, bus_a.overflow, bus_a.blank, bus_a.busy, bus_a.done}), 64'd0);
    chk("rst_b_outs",  64'({bus_b.bcd_out, bus_b.overflow, bus_b.blank, bus_b.busy, bus_b.done}), 64'd0);
    chk("rst_a_state", 64'(state_a), 64'd0);
    void'(exp_a_q.pop_back());
    void'(exp_b_q.pop_back());
    void'(load_q.pop_back());
    last_a = '0;
    last_b = '0;
    rst    = 1'b0;
    start  = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int unsigned directed[9] = '{1234, 0, 65535, 9, 10, 42, 999, 1000, 100};
    rst    = 1'b1;
    start  = 1'b0;
    bin_in = '0;
    repeat (2) @(negedge clk);
    chk("reset_a_outs", 64'({bus_a.bcd_out, bus_a.overflow, bus_a.blank, bus_a.busy, bus_a.done}), 64'd0);
    chk("reset_b_outs", 64'({bus_b.bcd_out, bus_b.overflow, bus_b.blank, bus_b.busy, bus_b.done}), 64'd0);
    chk("reset_state",  64'(state_a), 64'd0);
    rst = 1'b0;

    convert(directed[0], 0);
    foreach (directed[i]) if (i > 0) convert(directed[i], (i == 5) ? 10 : 1);
    reset_mid(500);
    convert(77, 2);
    for (int i = 0; i < 16; i++) convert($urandom_range(0, 65535), $urandom_range(0, 3));
    for (int i = 0; i < 4; i++) convert($urandom_range(0, 1100), $urandom_range(0, 2));

    repeat (3) @(negedge clk);
    chk("a_queue_drained", 64'(exp_a_q.size()), 64'd0);
    chk("b_queue_drained", 64'(exp_b_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
Sequential binary-to-BCD converter using double-dabble (shift-add-3), one bit per two clocks. It sits directly downstream of the square-root unit and the other arithmetic units in the FPGA calculator. It consumes their binary result and produces packed BCD digits for the 7-segment display driver. It uses the same level start/done handshake as the arithmetic units, so the calculator sequencer drives every unit the same way.

Parameters:
WIDTH, 16, bit width of the binary input (unsigned).
DIGITS, 5, number of BCD output digits; the valid range is DIGITS*4 >= 4.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  level request; held high by the sequencer until done is seen, then dropped.
bin_in  input  WIDTH  unsigned binary value; sampled only on the load edge.
bcd_out  output  4*DIGITS  packed BCD result, digit 0 in [3:0]; registered.
overflow  output  1  high when bin_in exceeds 10^DIGITS-1; registered with bcd_out.
blank  output  DIGITS  leading-zero blank mask; see Optional Feature.
busy  output  1  high from the load edge until DONE is entered.
done  output  1  result valid; held high until start is low.

Behaviour:
- Reset: synchronous on rst=1 at the rising edge, from any state including mid-conversion.
  - Next state is IDLE.
  - bcd_out, overflow, blank, busy and done all go to 0.
  - Shift register and counter are cleared.
- IDLE:
  - If start=1, the next edge loads bin_in into the low part of a WIDTH+4*DIGITS shift register.
  - The BCD part of the shift register is zeroed, count is set to WIDTH, busy goes to 1, and the next state is ADJ.
  - If start=0, the FSM stays in IDLE.
- ADJ:
  - Every 4-bit BCD digit >= 5 gets +3, in one cycle.
  - Digits are evaluated in parallel from the pre-adjust values.
  - Next state is SHIFT.
- SHIFT:
  - The full register shifts left by 1.
  - The bit shifted out of the top digit sets a sticky overflow_acc.
  - count is decremented.
  - If the decremented count is 0, the next state is DONE; otherwise ADJ.
- DONE:
  - On entry edge: bcd_out <= BCD field, overflow <= overflow_acc, busy <= 0, done <= 1.
  - The FSM stays in DONE while start=1.
  - When start=0, done <= 0 and the next state is IDLE.
  - start re-asserted in the same cycle it drops is not possible; a new request needs at least one cycle low.
- Latency: the edge that samples start in IDLE is edge 0; done is high after edge 1+2*WIDTH (33 for WIDTH=16).
- bcd_out and overflow:
  - Both hold the previous result throughout a conversion and change only on DONE entry.
  - bin_in changes after the load edge are ignored.
- Overflow: if the value does not fit, bcd_out holds the low DIGITS digits of the true BCD value.
- start: ignored in ADJ/SHIFT. A start drop mid-conversion does not abort; DONE is entered and then exits on the next cycle because start=0.
- Counter width: clog2(WIDTH+1). WIDTH=1 is legal and takes 1 ADJ/SHIFT pair.

Optional Feature:
LEADING_ZERO_BLANK_EN:
- Defined: on DONE entry, blank[i]=1 for every digit i above the most significant nonzero digit.
  - Digit 0 is never blanked, so a value of 0 shows "0".
  - With overflow=1, blank is all zeros.
  - blank is registered alongside bcd_out and cleared on reset.
- Undefined: blank is constant 0. The port remains so the display wiring is unchanged.

Test Plan:
- WIDTH=16, DIGITS=5, rst held for 2 cycles, then bin_in=1234 with start held -> done=1 exactly 33 edges after the load edge, bcd_out=20'h01234, overflow=0, busy low at DONE entry.
- Boundary values: bin_in=0 -> bcd_out=20'h00000. bin_in=65535 -> bcd_out=20'h65535, overflow=0. bin_in=9 then 10 -> 20'h00009 then 20'h00010.
- Handshake: start held 10 cycles after done -> done and bcd_out stable. Drop start -> done=0 the next edge and the FSM is back in IDLE. Re-raise start with bin_in=42 -> new result 20'h00042; the old value is visible until DONE.
- Reset mid-operation: rst=1 at edge 10 of a conversion of 500 -> all outputs 0 the next edge. A following start with 77 converts correctly to 20'h00077.
- Overflow: DIGITS=3 with bin_in=1000 -> overflow=1, bcd_out=12'h000. DIGITS=3 with bin_in=999 -> overflow=0, bcd_out=12'h999.
- With LEADING_ZERO_BLANK_EN: 1234 -> blank=5'b10000. 0 -> blank=5'b11110. 65535 -> 5'b00000. Without the macro, blank=0 for all three values.
